// File: rtl/piso_shift_reg_param.sv
// rtl/piso_shift_reg_param.sv - parametrised PISO shift register with load handshake and frame markers
module piso_shift_reg_param #(
    parameter int WIDTH = 8,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic [CW-1:0]    bits_left,
    output logic [WIDTH-1:0] q_bar
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_reg_n;
    logic [CW-1:0]    count, count_n;
    logic             order, order_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            order     <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_reg_n;
            count     <= count_n;
            order     <= order_n;
        end
    end

    // din_ready opens on the final bit so the next word loads on the same edge
    assign din_ready = (state == IDLE) || ((state == SHIFT) && (count == '0) && shift_en);

    always_comb begin
        state_n     = state;
        shift_reg_n = shift_reg;
        count_n     = count;
        order_n     = order;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    shift_reg_n = din;
                    order_n     = lsb_first;
                    count_n     = CW'(WIDTH - 1);
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (count != '0) begin
                        shift_reg_n = order ? (shift_reg >> 1) : (shift_reg << 1);
                        count_n     = count - CW'(1);
                    end else if (din_valid) begin
                        shift_reg_n = din;
                        order_n     = lsb_first;
                        count_n     = CW'(WIDTH - 1);
                    end else begin
                        shift_reg_n = '0;
                        state_n     = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid & (order ? shift_reg[0] : shift_reg[WIDTH-1]);
    assign ser_last  = ser_valid && (count == '0);
    assign bits_left = count;
    assign q_bar     = ~shift_reg;

endmodule

// File: doc/piso_shift_reg_param.md
Name: piso_shift_reg_param

Overview:
Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, a selectable shift direction, stall control and frame markers. It accepts a WIDTH-bit word, serialises it one bit per enabled clock, and can accept the next word back-to-back with no bubble. It is the generalised successor to the fixed 4-bit PISO and serves as the serial transmit front-end for the team's serial datapaths.

Parameters:
WIDTH, 8, parallel word width in bits (≥1).
CW, $clog2(WIDTH) (minimum 1), width of the bit counter (derived; must not be overridden).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
din  in  WIDTH  parallel data word
din_valid  in  1  din holds a word to load
din_ready  out  1  block can accept a word this cycle
lsb_first  in  1  bit order of the word; sampled on load (1 = LSB first, 0 = MSB first)
shift_en  in  1  consumer takes the current serial bit this cycle; 0 = stall
ser_out  out  1  current serial bit
ser_valid  out  1  ser_out is valid
ser_last  out  1  ser_out is the final bit of the word
bits_left  out  CW  bits remaining after the current bit
q_bar  out  WIDTH  bitwise inverse of the internal shift register

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over every other input.
- Reset state: state = IDLE; shift_reg = 0; count = 0; order flag = 0 (MSB first).
  - Resulting outputs: ser_valid = 0, ser_last = 0, ser_out = 0, bits_left = 0, q_bar = all ones, din_ready = 1.
- State IDLE:
  - din_ready = 1; ser_valid = 0.
  - din_valid = 1 → load on the clock edge: shift_reg ← din, order flag ← lsb_first, count ← WIDTH−1, go to SHIFT.
  - din_valid = 0 → stay in IDLE.
- State SHIFT:
  - ser_valid = 1.
  - ser_out = shift_reg[0] when the order flag is 1, else shift_reg[WIDTH−1].
  - bits_left = count; ser_last = (count == 0).
- Shift step: shift_en = 1 and count ≠ 0 consumes the current bit.
  - LSB first: shift right, zero fill at the MSB.
  - MSB first: shift left, zero fill at the LSB.
  - count decrements by 1.
- Stall: shift_en = 0 holds shift_reg, count and all outputs unchanged. Stalls may last any number of cycles.
- Last bit: shift_en = 1 with count == 0 consumes the final bit.
  - din_valid = 1: load the new word on the same edge with no idle cycle; stay in SHIFT, count ← WIDTH−1, order flag re-sampled.
  - din_valid = 0: shift_reg ← 0, go to IDLE.
- din_ready = IDLE OR (SHIFT AND count == 0 AND shift_en). This is combinational from registered state and shift_en.
- din_valid while din_ready = 0 is ignored; the word is not captured. The upstream block must hold it.
- Latency:
  - Word accepted at edge N → first bit is on ser_out after edge N.
  - The last bit is consumed at the WIDTH-th enabled edge after N.
  - Back-to-back throughput is one bit per shift_en cycle.
- Outputs: all outputs derive from registered state only, except din_ready, which also depends on shift_en.
- WIDTH = 1: every word has count = 0 in SHIFT, so ser_last = 1 throughout.
- Reset mid-word: the word is discarded and the block returns to the reset state on that edge. No partial bits are emitted afterwards.
- lsb_first changes while in SHIFT have no effect until the next load.
- q_bar = ~shift_reg at all times, including in IDLE.

Test Plan:
1. WIDTH=8, load 0xA5 with lsb_first=1 and shift_en held at 1 → ser_out = 1,0,1,0,0,1,0,1 over 8 cycles. ser_last high only on the 8th bit. bits_left counts 7→0. Block then returns to IDLE with ser_valid=0.
2. Load 0xA5 with lsb_first=0 → ser_out = 1,0,1,0,0,1,0,1 (MSB first). Load 0x0F with lsb_first=0 → 0,0,0,0,1,1,1,1.
3. Back-to-back: 0x81 then 0x7E, din_valid held, shift_en held at 1 → 16 contiguous valid bits with no ser_valid gap. din_ready pulses high only on the cycle of the last bit of the first word.
4. Stall: load 0xC3 (LSB first), drop shift_en for 3 cycles after the 2nd bit → ser_out, bits_left=5 and q_bar=0xCF are held during the stall. The bit sequence resumes intact: 1,1,0,0,0,0,1,1.
5. Assert rst during the 4th bit of 0xFF → the next cycle shows ser_valid=0, q_bar=0xFF, din_ready=1. A following load of 0x01 serialises correctly.
6. din_valid=1 while mid-word with count≠0 → the new word is not captured and the current word completes unchanged.
